// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single pipelined 4-cycle main memory port between
// I-cache block fills, D-cache block fills and D-cache write-throughs.
// Fill words are handed back combinationally as they arrive, tagged with their
// index in the block. The done strobe fires on the 8th returned word.
//
// state  | meaning
// IDLE   | nothing in flight; fixed-priority grant I fill > D write > D fill
// IFILL  | issuing the 8 block reads for the I-cache, counting returned words
// DFILL  | as IFILL, for the D-cache
// DWRITE | one-cycle write-through presented on the memory port
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int WORD_IDX_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_fill_req,
    input  logic [ADDR_W-1:0]     i_fill_addr,
    input  logic                  d_fill_req,
    input  logic [ADDR_W-1:0]     d_fill_addr,
    input  logic                  d_wr_req,
    input  logic [ADDR_W-1:0]     d_wr_addr,
    input  logic [DATA_W-1:0]     d_wr_data,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_data_valid,
    output logic                  i_busy,
    output logic                  d_busy,
    output logic [DATA_W-1:0]     fill_data,
    output logic [WORD_IDX_W-1:0] fill_word,
    output logic                  i_fill_valid,
    output logic                  d_fill_valid,
    output logic                  i_fill_done,
    output logic                  d_fill_done,
    output logic                  d_wr_ack
);

    localparam int BASE_W = ADDR_W - WORD_IDX_W - 1;

    typedef enum logic [1:0] {IDLE, IFILL, DFILL, DWRITE} state_t;

    state_t                  state_q;
    logic [BASE_W-1:0]       base_q;
    logic [WORD_IDX_W-1:0]   iss_q;
    logic [WORD_IDX_W-1:0]   ret_q;
    logic                    iss_done_q;
    logic                    mem_en_q;
    logic                    mem_wr_q;
    logic [ADDR_W-1:0]       mem_addr_q;
    logic [DATA_W-1:0]       mem_wdata_q;
    logic                    d_wr_ack_q;

    logic                    i_valid_d;
    logic                    d_valid_d;
    logic                    last_word_d;
    logic                    i_done_d;
    logic                    d_done_d;

    // Byte-offset bits of the miss addresses and the write address LSB carry no
    // information for the memory port.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_fill_addr[WORD_IDX_W:0], d_fill_addr[WORD_IDX_W:0], d_wr_addr[0]};

    // Sequencer: arbitration, read issue, return counting and registered memory-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            iss_q       <= '0;
            ret_q       <= '0;
            iss_done_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            d_wr_ack_q  <= 1'b0;
        end else begin
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            d_wr_ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    iss_q      <= '0;
                    ret_q      <= '0;
                    iss_done_q <= 1'b0;
                    if (i_fill_req) begin
                        state_q <= IFILL;
                        base_q  <= i_fill_addr[ADDR_W-1:WORD_IDX_W+1];
                    end else if (d_wr_req) begin
                        // Write presents on the port during the DWRITE cycle itself.
                        state_q     <= DWRITE;
                        mem_en_q    <= 1'b1;
                        mem_wr_q    <= 1'b1;
                        mem_addr_q  <= {d_wr_addr[ADDR_W-1:1], 1'b0};
                        mem_wdata_q <= d_wr_data;
                        d_wr_ack_q  <= 1'b1;
                    end else if (d_fill_req) begin
                        state_q <= DFILL;
                        base_q  <= d_fill_addr[ADDR_W-1:WORD_IDX_W+1];
                    end
                end
                IFILL, DFILL: begin
                    if (!iss_done_q) begin
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= {base_q, iss_q, 1'b0};
                        iss_q      <= iss_q + WORD_IDX_W'(1);
                        if (iss_q == '1) begin
                            iss_done_q <= 1'b1;
                        end
                    end
                    // Completion follows returned words, so a slow memory only stretches the fill.
                    if (mem_data_valid) begin
                        ret_q <= ret_q + WORD_IDX_W'(1);
                        if (ret_q == '1) begin
                            state_q <= IDLE;
                        end
                    end
                end
                DWRITE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Returned-word pass-through, done strobes and stall signals.
    always_comb begin
        i_valid_d   = mem_data_valid & (state_q == IFILL);
        d_valid_d   = mem_data_valid & (state_q == DFILL);
        last_word_d = (ret_q == '1);
        i_done_d    = i_valid_d & last_word_d;
        d_done_d    = d_valid_d & last_word_d;
        i_busy      = rst_n & i_fill_req & ~i_done_d;
        d_busy      = rst_n & ((d_fill_req & ~d_done_d) | (d_wr_req & ~d_wr_ack_q));
        fill_data   = (i_valid_d | d_valid_d) ? mem_rdata : '0;
        fill_word   = (i_valid_d | d_valid_d) ? ret_q : '0;
    end

    assign i_fill_valid = i_valid_d;
    assign d_fill_valid = d_valid_d;
    assign i_fill_done  = i_done_d;
    assign d_fill_done  = d_done_d;
    assign d_wr_ack     = d_wr_ack_q;
    assign mem_en       = mem_en_q;
    assign mem_wr       = mem_wr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: pipelined 4-cycle memory model, a cache-side model
// that drops each request on its done/ack, a transaction-level expectation
// model checked every cycle, and literal per-scenario expectations.
module tb_mem_arbiter;

    localparam int OP_NONE = 0;
    localparam int OP_IF   = 1;
    localparam int OP_DF   = 2;
    localparam int OP_DW   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_fill_req, d_fill_req, d_wr_req;
    logic [15:0] i_fill_addr, d_fill_addr, d_wr_addr, d_wr_data;
    logic        mem_en, mem_wr, mem_data_valid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        i_busy, d_busy;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_valid, d_fill_valid, i_fill_done, d_fill_done, d_wr_ack;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WORD_IDX_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_fill_req(i_fill_req), .i_fill_addr(i_fill_addr),
        .d_fill_req(d_fill_req), .d_fill_addr(d_fill_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .i_busy(i_busy), .d_busy(d_busy),
        .fill_data(fill_data), .fill_word(fill_word),
        .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
        .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .d_wr_ack(d_wr_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- memory model: read issued in cycle c returns in cycle c+4
    logic [15:0] mem_pat;
    logic [15:0] mq_data[$];
    int          mq_rdy[$];
    bit          gap_en;
    int          gap_cnt, gap_hold, out_idx;
    bit          spurious;

    always @(negedge clk) begin
        if (mem_en === 1'b1 && mem_wr === 1'b0) begin
            mq_data.push_back(mem_pat + {13'd0, mem_addr[3:1]});
            mq_rdy.push_back(cyc + 4);
        end
    end

    always @(posedge clk) begin
        #1;
        mem_data_valid = 1'b0;
        mem_rdata      = 16'h0000;
        if (gap_cnt > 0) begin
            gap_cnt--;
        end else if (mq_rdy.size() > 0 && mq_rdy[0] <= cyc) begin
            if (gap_en && (out_idx == 2 || out_idx == 5) && gap_hold != out_idx) begin
                gap_hold = out_idx;
                gap_cnt  = 1;
            end else begin
                mem_data_valid = 1'b1;
                mem_rdata      = mq_data.pop_front();
                void'(mq_rdy.pop_front());
                out_idx++;
            end
        end
        if (spurious) begin
            mem_data_valid = 1'b1;
            mem_rdata      = 16'h5555;
            spurious       = 1'b0;
        end
    end

    // ---------------- cache side: hold each request until its done/ack
    initial begin : cache_side
        logic di, dw, df;
        forever begin
            @(negedge clk);
            di = i_fill_done;
            dw = d_wr_ack;
            df = d_fill_done;
            @(posedge clk);
            #1;
            if (di === 1'b1) i_fill_req = 1'b0;
            if (dw === 1'b1) d_wr_req = 1'b0;
            if (df === 1'b1) d_fill_req = 1'b0;
        end
    end

    // ---------------- observation logs (actual DUT behaviour)
    int en_cyc[$], en_addr[$];
    int wr_cyc[$], wr_addr[$], wr_data[$];
    int iv_cyc[$], iv_word[$], iv_data[$], id_cyc[$];
    int dv_cyc[$], dv_word[$], dv_data[$], dd_cyc[$];
    int ack_cyc[$];
    logic ib_hist[int];
    logic db_hist[int];

    task automatic clear_logs();
        en_cyc.delete(); en_addr.delete();
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        iv_cyc.delete(); iv_word.delete(); iv_data.delete(); id_cyc.delete();
        dv_cyc.delete(); dv_word.delete(); dv_data.delete(); dd_cyc.delete();
        ack_cyc.delete();
    endtask

    // ---------------- transaction-level expectation model
    int          m_op = OP_NONE;
    int          m_start, m_cnt, k;
    logic [11:0] m_base;
    logic [15:0] m_waddr, m_wdata, e_addr;
    logic        e_en, e_wr, e_iv, e_dv, e_id, e_dd, e_ack, e_last;

    always @(negedge clk) begin
        if (mem_en === 1'b1 && mem_wr === 1'b0) begin en_cyc.push_back(cyc); en_addr.push_back(int'(mem_addr)); end
        if (mem_en === 1'b1 && mem_wr === 1'b1) begin
            wr_cyc.push_back(cyc); wr_addr.push_back(int'(mem_addr)); wr_data.push_back(int'(mem_wdata));
        end
        if (i_fill_valid === 1'b1) begin iv_cyc.push_back(cyc); iv_word.push_back(int'(fill_word)); iv_data.push_back(int'(fill_data)); end
        if (d_fill_valid === 1'b1) begin dv_cyc.push_back(cyc); dv_word.push_back(int'(fill_word)); dv_data.push_back(int'(fill_data)); end
        if (i_fill_done === 1'b1) id_cyc.push_back(cyc);
        if (d_fill_done === 1'b1) dd_cyc.push_back(cyc);
        if (d_wr_ack === 1'b1) ack_cyc.push_back(cyc);
        ib_hist[cyc] = i_busy;
        db_hist[cyc] = d_busy;

        if (!rst_n) begin
            chk("rst_outputs_zero",
                {mem_en, mem_wr, i_busy, d_busy, i_fill_valid, d_fill_valid, i_fill_done, d_fill_done, d_wr_ack},
                32'd0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_fill_data", fill_data, 0);
            chk("rst_fill_word", fill_word, 0);
            m_op = OP_NONE;
        end else begin
            e_en = 0; e_wr = 0; e_iv = 0; e_dv = 0; e_id = 0; e_dd = 0; e_ack = 0; e_last = 0;
            e_addr = 16'h0;
            if (m_op == OP_IF || m_op == OP_DF) begin
                k = cyc - m_start;
                if (k >= 1 && k <= 8) begin
                    e_en   = 1;
                    e_addr = {m_base, 3'(k - 1), 1'b0};
                end
                if (mem_data_valid) begin
                    e_last = (m_cnt == 7);
                    if (m_op == OP_IF) begin e_iv = 1; e_id = e_last; end
                    else               begin e_dv = 1; e_dd = e_last; end
                end
            end else if (m_op == OP_DW) begin
                e_en = 1; e_wr = 1; e_ack = 1;
                e_addr = m_waddr & 16'hFFFE;
            end
            chk("mem_en", mem_en, e_en);
            chk("mem_wr", mem_wr, e_wr);
            if (e_en) chk("mem_addr", mem_addr, e_addr);
            if (e_wr) chk("mem_wdata", mem_wdata, m_wdata);
            chk("i_fill_valid", i_fill_valid, e_iv);
            chk("d_fill_valid", d_fill_valid, e_dv);
            chk("i_fill_done", i_fill_done, e_id);
            chk("d_fill_done", d_fill_done, e_dd);
            chk("d_wr_ack", d_wr_ack, e_ack);
            if (e_iv || e_dv) begin
                chk("fill_data", fill_data, mem_rdata);
                chk("fill_word", fill_word, m_cnt);
                m_cnt++;
            end
            chk("i_busy", i_busy, i_fill_req & ~e_id);
            chk("d_busy", d_busy, (d_fill_req & ~e_dd) | (d_wr_req & ~e_ack));

            if (m_op == OP_DW || e_last) begin
                m_op = OP_NONE;
            end else if (m_op == OP_NONE) begin
                m_start = cyc + 1;
                m_cnt   = 0;
                if (i_fill_req) begin
                    m_op = OP_IF; m_base = i_fill_addr[15:4];
                end else if (d_wr_req) begin
                    m_op = OP_DW; m_waddr = d_wr_addr; m_wdata = d_wr_data;
                end else if (d_fill_req) begin
                    m_op = OP_DF; m_base = d_fill_addr[15:4];
                end
            end
        end
    end

    // ---------------- helpers
    task automatic wait_quiet(input int maxc, input string nm);
        int  n;
        bit  quiet;
        n = 0;
        quiet = 0;
        while (!quiet && n < maxc) begin
            @(negedge clk);
            n++;
            quiet = !i_fill_req && !d_fill_req && !d_wr_req && (mq_rdy.size() == 0) && (gap_cnt == 0);
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL timeout_%s: not quiet after %0d cycles", nm, maxc);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus
    initial begin
        int c0;
        int lows;
        i_fill_req = 0; d_fill_req = 0; d_wr_req = 0;
        i_fill_addr = 0; d_fill_addr = 0; d_wr_addr = 0; d_wr_data = 0;
        mem_data_valid = 0; mem_rdata = 0;
        mem_pat = 16'hA000; gap_en = 0; gap_cnt = 0; gap_hold = -1; out_idx = 0; spurious = 0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // I fill of the block at 0x1230
        clear_logs();
        mem_pat = 16'hA000;
        i_fill_addr = 16'h1236; i_fill_req = 1; c0 = cyc;
        wait_quiet(60, "ifill");
        chk("ifill_reads", en_addr.size(), 8);
        chk("ifill_addr0", en_addr[0], 16'h1230);
        chk("ifill_addr7", en_addr[7], 16'h123E);
        chk("ifill_issue_cyc0", en_cyc[0], c0 + 2);
        chk("ifill_issue_cyc7", en_cyc[7], c0 + 9);
        chk("ifill_nvalid", iv_cyc.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("ifill_word", iv_word[i], i);
            chk("ifill_data", iv_data[i], 16'hA000 + i);
            chk("ifill_vcyc", iv_cyc[i], c0 + 6 + i);
        end
        chk("ifill_ndone", id_cyc.size(), 1);
        chk("ifill_done_cyc", id_cyc[0], c0 + 13);
        chk("ifill_no_dvalid", dv_cyc.size(), 0);
        chk("ifill_busy_before_done", ib_hist[c0 + 12], 1);
        chk("ifill_busy_after", ib_hist[c0 + 14], 0);

        // Single write-through
        clear_logs();
        d_wr_addr = 16'h4001; d_wr_data = 16'hBEEF; d_wr_req = 1; c0 = cyc;
        wait_quiet(20, "write");
        chk("wr_count", wr_cyc.size(), 1);
        chk("wr_cyc", wr_cyc[0], c0 + 1);
        chk("wr_addr", wr_addr[0], 16'h4000);
        chk("wr_data", wr_data[0], 16'hBEEF);
        chk("wr_ack_count", ack_cyc.size(), 1);
        chk("wr_ack_cyc", ack_cyc[0], c0 + 1);
        chk("wr_no_strobes", iv_cyc.size() + dv_cyc.size() + en_cyc.size(), 0);

        // All three requests together
        clear_logs();
        i_fill_addr = 16'h2004; d_wr_addr = 16'h5003; d_wr_data = 16'h1234; d_fill_addr = 16'h300A;
        i_fill_req = 1; d_wr_req = 1; d_fill_req = 1; c0 = cyc;
        wait_quiet(100, "prio");
        chk("prio_idone_cyc", id_cyc[0], c0 + 13);
        chk("prio_wr_cyc", wr_cyc[0], c0 + 15);
        chk("prio_wr_addr", wr_addr[0], 16'h5002);
        chk("prio_en_addr_i", en_addr[0], 16'h2000);
        chk("prio_en_addr_d", en_addr[8], 16'h3000);
        chk("prio_en_cyc_d", en_cyc[8], c0 + 18);
        chk("prio_ddone_cyc", dd_cyc[0], c0 + 29);
        chk("prio_dvalid_n", dv_cyc.size(), 8);
        chk("prio_dlast_data", dv_data[7], 16'hA007);
        lows = 0;
        for (int c = c0; c < c0 + 29; c++) if (db_hist[c] !== 1'b1) lows++;
        chk("prio_dbusy_held", lows, 0);

        // D fill with the 3rd and 6th words held back 2 cycles each
        clear_logs();
        mem_pat = 16'hD000; gap_en = 1; gap_hold = -1; out_idx = 0;
        d_fill_addr = 16'h7770; d_fill_req = 1; c0 = cyc;
        wait_quiet(80, "gap");
        gap_en = 0;
        chk("gap_nvalid", dv_cyc.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("gap_word", dv_word[i], i);
            chk("gap_data", dv_data[i], 16'hD000 + i);
        end
        chk("gap_v3_cyc", dv_cyc[2], c0 + 10);
        chk("gap_last_cyc", dv_cyc[7], c0 + 17);
        chk("gap_ndone", dd_cyc.size(), 1);
        chk("gap_done_cyc", dd_cyc[0], c0 + 17);
        chk("gap_no_ivalid", iv_cyc.size(), 0);

        // Reset in the middle of an I fill
        clear_logs();
        mem_pat = 16'hA000;
        i_fill_addr = 16'h0100; i_fill_req = 1; c0 = cyc;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_mem_en", mem_en, 0);
        chk("midrst_i_busy", i_busy, 0);
        chk("midrst_stray_ivalid", i_fill_valid, 0);
        chk("midrst_fill_data", fill_data, 0);
        @(posedge clk);
        #1 i_fill_req = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_quiet(40, "rst_flush");
        chk("midrst_valids_total", iv_cyc.size(), 1);
        chk("midrst_first_word", iv_word[0], 0);
        clear_logs();
        i_fill_addr = 16'h0200; i_fill_req = 1;
        wait_quiet(60, "rst_refill");
        chk("refill_nvalid", iv_cyc.size(), 8);
        chk("refill_word0", iv_word[0], 0);
        chk("refill_data0", iv_data[0], 16'hA000);
        chk("refill_addr0", en_addr[0], 16'h0200);
        chk("refill_ndone", id_cyc.size(), 1);

        // Spurious valid while idle, then a D fill
        clear_logs();
        @(negedge clk);
        spurious = 1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("spur_no_ivalid", i_fill_valid, 0);
        chk("spur_no_dvalid", d_fill_valid, 0);
        @(posedge clk);
        #1;
        mem_pat = 16'h1000; d_fill_addr = 16'h6000; d_fill_req = 1;
        wait_quiet(60, "spur_fill");
        chk("spur_nvalid", dv_cyc.size(), 8);
        chk("spur_word0", dv_word[0], 0);
        chk("spur_word7", dv_word[7], 7);
        chk("spur_data0", dv_data[0], 16'h1000);
        chk("spur_ndone", dd_cyc.size(), 1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the I-cache/D-cache fill logic and the single shared 4-cycle main memory (memory4c).
- Serialises three request types onto the one memory port: instruction block fills, data block fills, and data write-throughs.
- For fills, it generates word addresses and counts returned words. It hands each word to the requesting cache with its word index, then pulses a done/tag-write strobe.
- Replaces ad-hoc muxing of the memory enable and address between the two caches.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, data width in bits.
- WORD_IDX_W, 3, log2 of words per block (8 words of 2 bytes = 16-byte block).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_fill_req  in  1  I-cache miss; held high until i_fill_done
- i_fill_addr  in  ADDR_W  I-cache miss address; bits [3:0] ignored
- d_fill_req  in  1  D-cache miss; held high until d_fill_done
- d_fill_addr  in  ADDR_W  D-cache miss address; bits [3:0] ignored
- d_wr_req  in  1  data write-through request; held high until d_wr_ack
- d_wr_addr  in  ADDR_W  write address
- d_wr_data  in  DATA_W  write data
- mem_en  out  1  memory enable
- mem_wr  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_data_valid  in  1  memory read data valid; arrives 4 cycles after the read is issued; reads are pipelined
- i_busy  out  1  I-side stall
- d_busy  out  1  D-side stall
- fill_data  out  DATA_W  returned word; shared by both caches
- fill_word  out  WORD_IDX_W  index of the returned word within the block
- i_fill_valid  out  1  fill_data is for the I-cache
- d_fill_valid  out  1  fill_data is for the D-cache
- i_fill_done  out  1  one-cycle pulse; I-cache tag write
- d_fill_done  out  1  one-cycle pulse; D-cache tag write
- d_wr_ack  out  1  one-cycle pulse; write issued

Behaviour:
- States: IDLE, IFILL, DFILL, DWRITE.
- Reset is asynchronous and active-low. On reset:
  - state=IDLE; issue counter and return counter = 0; latched base = 0.
  - All outputs are 0, including mem_en, mem_wr, every valid/done/ack strobe, both busy signals, fill_data and fill_word.
- IDLE arbitration is fixed priority: i_fill_req > d_wr_req > d_fill_req. The grant registers the base address (addr[15:4]) and moves to the target state on the next edge.
- Busy signals:
  - i_busy = i_fill_req & ~i_fill_done (combinational).
  - d_busy = (d_fill_req & ~d_fill_done) | (d_wr_req & ~d_wr_ack).
- IFILL/DFILL, with grant edge at cycle 0:
  - Cycles 1..8: mem_en=1, mem_wr=0, mem_addr={base,k[2:0],1'b0}, with k = 0..7 over those cycles.
  - Each mem_data_valid: fill_data=mem_rdata, fill_word=return counter, and the matching *_fill_valid=1 in the same cycle (combinational pass-through); the return counter then increments.
  - On the 8th valid (counter==7): *_fill_done pulses in the same cycle as the last *_fill_valid; state goes to IDLE on the next edge.
  - Nominal: data in cycles 5..12; done in cycle 12; IDLE in cycle 13; a new grant is possible at the cycle-13 edge.
- Completion is counted by valids, not by time. A late or gapped memory must still yield exactly 8 words and one done pulse.
- DWRITE, one cycle: mem_en=1, mem_wr=1, mem_addr=d_wr_addr with bit0 forced to 0, mem_wdata=d_wr_data, d_wr_ack=1. Returns to IDLE on the next edge.
- No overlap: a new grant happens only from IDLE, so no reads are outstanding when a write is issued.
- mem_data_valid received in IDLE or DWRITE is ignored: no fill_valid and no counter change.
- A request that drops mid-operation does not abort it; the fill completes and the done pulse still fires.
- Simultaneous requests: all three high in IDLE are served I fill, then D write, then D fill, one after another with one IDLE cycle between each.
- An I request arriving during a DFILL waits for the DFILL to finish; there is no preemption.
- A reset during a fill returns to IDLE immediately. The first valid after reset is ignored, as for any valid in IDLE.
- Counter wrap: the 3-bit counters wrap 7->0, and that wrap coincides with leaving the fill state.

Test Plan:
- I fill: i_fill_req=1, i_fill_addr=0x1236 -> mem_addr 0x1230,0x1232,...,0x123E on cycles 1..8. With the memory returning 0xA000+k: i_fill_valid cycles 5..12, fill_word 0..7, fill_data 0xA000..0xA007; i_fill_done in cycle 12 only; i_busy low from cycle 13.
- Priority: i_fill_req, d_wr_req and d_fill_req all asserted at once -> order I fill (addr base from i_fill_addr), then d write (mem_wr=1 one cycle, d_wr_ack), then D fill. d_busy stays high throughout until the respective ack/done.
- Write: d_wr_addr=0x4001, d_wr_data=0xBEEF -> one cycle of mem_en=1, mem_wr=1, mem_addr=0x4000, mem_wdata=0xBEEF, d_wr_ack=1; no fill strobes.
- Gapped memory: in a D fill, delay the 3rd and 6th valids by 2 cycles each -> still exactly 8 d_fill_valid with fill_word 0..7; d_fill_done on the 8th valid; i_fill_valid never asserted.
- Reset in the middle of a fill (rst_n low at cycle 6) -> all outputs 0 immediately. Stray mem_data_valid afterwards produces no fill_valid. A subsequent fill restarts at word 0.
- Spurious valid: mem_data_valid=1 in IDLE -> no strobes; the next fill's fill_word starts at 0.
